scan_addr_sequencer: RTL and testbench

Synchronous address sequencer that generates the 4-bit select `a` and enable `en` for a 4-to-16 one-hot decoder stage. It steps the select through positions 0–15 using a programmable dwell prescaler, or one position at a time from a manual step input. It supports up, down, ping-pong and hold patterns, and typically drives LED chase or row-scan logic. All outputs are registered and connect directly to the decoder's `en` and `a` inputs.

---
 rtl/scan_addr_sequencer.sv | 125 ++++++++++++
 tb/tb_scan_addr_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_addr_sequencer.sv
//----------------------------------------------------------------------------
// Module      : scan_addr_sequencer
// Description : Position sequencer for a 4-to-16 decoder with a dwell prescaler,
//               manual stepping and up/down/ping-pong/hold patterns.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module scan_addr_sequencer #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         step,
  input  logic [1:0]   mode,
  input  logic [N-1:0] dvsr,
  input  logic         show,
  output logic         en,
  output logic [3:0]   a,
  output logic         tick,
  output logic         wrap
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [1:0] c_MODE_UP   = 2'b00;
  localparam logic [1:0] c_MODE_DOWN = 2'b01;
  localparam logic [1:0] c_MODE_PING = 2'b10;

  logic [N-1:0] count_q, count_d;
  logic [3:0]   a_q, a_d;
  dir_e         dir_q, dir_d;
  logic         step_q;
  logic         tick_q, wrap_q, wrap_d;
  logic         en_q;
  logic         w_adv;

  always_comb begin
    count_d = count_q;
    w_adv   = 1'b0;
    a_d     = a_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;

    // >= (not ==) so a dvsr lowered below the running count fires immediately
    if (run) begin
      if (count_q >= dvsr) begin
        count_d = '0;
        w_adv   = 1'b1;
      end else begin
        count_d = count_q + N'(1);
      end
    end else begin
      count_d = '0;
      w_adv   = step & ~step_q;
    end

    if (w_adv) begin
      case (mode)
        c_MODE_UP: begin
          a_d    = a_q + 4'd1;
          wrap_d = (a_q == 4'd15);
          dir_d  = DIR_UP;
        end
        c_MODE_DOWN: begin
          a_d    = a_q - 4'd1;
          wrap_d = (a_q == 4'd0);
          dir_d  = DIR_DOWN;
        end
        c_MODE_PING: begin
          if (dir_q == DIR_UP) begin
            if (a_q == 4'd15) begin
              a_d    = 4'd14;
              dir_d  = DIR_DOWN;
              wrap_d = 1'b1;
            end else begin
              a_d = a_q + 4'd1;
            end
          end else begin
            if (a_q == 4'd0) begin
              a_d    = 4'd1;
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              a_d = a_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      a_q     <= 4'd0;
      dir_q   <= DIR_UP;
      step_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      a_q     <= a_d;
      dir_q   <= dir_d;
      step_q  <= step;
      tick_q  <= w_adv;
      wrap_q  <= wrap_d;
      en_q    <= show;
    end
  end

  assign en   = en_q;
  assign a    = a_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_addr_sequencer.sv
//----------------------------------------------------------------------------
// Module      : tb_scan_addr_sequencer
// Description : Scoreboard bench for scan_addr_sequencer.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_scan_addr_sequencer;

  localparam int N = 24;

  logic         clk;
  logic         reset;
  logic         run;
  logic         step;
  logic [1:0]   mode;
  logic [N-1:0] dvsr;
  logic         show;
  logic         en;
  logic [3:0]   a;
  logic         tick;
  logic         wrap;

  scan_addr_sequencer #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .step  (step),
    .mode  (mode),
    .dvsr  (dvsr),
    .show  (show),
    .en    (en),
    .a     (a),
    .tick  (tick),
    .wrap  (wrap)
  );

  typedef struct packed {
    logic [3:0] a;
    logic       tick;
    logic       wrap;
    logic       en;
  } exp_t;

  exp_t q_exp[$];

  int n_vec  = 0;
  int n_err  = 0;
  int obs_ticks = 0;
  int obs_wraps = 0;

  // reference state
  int m_a   = 0;
  int m_dir = 0;
  int m_cnt = 0;
  int m_sq  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: the model consumes the inputs at the edge, pushes its
  // prediction, and the DUT outputs are compared on the following falling edge.
  task automatic cyc();
    exp_t e;
    int   na;
    int   nw;
    bit   adv;
    @(posedge clk);
    if (reset) begin
      m_a = 0; m_dir = 0; m_cnt = 0; m_sq = 0;
      e = '{a: 4'd0, tick: 1'b0, wrap: 1'b0, en: 1'b0};
    end else begin
      adv = 1'b0;
      if (run) begin
        if (m_cnt >= int'(dvsr)) begin
          adv = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
        adv = (step == 1'b1) && (m_sq == 0);
      end
      m_sq = int'(step);
      na = m_a;
      nw = 0;
      if (adv) begin
        case (mode)
          2'b00: begin na = (m_a + 1) % 16;  nw = (m_a == 15); m_dir = 0; end
          2'b01: begin na = (m_a + 15) % 16; nw = (m_a == 0);  m_dir = 1; end
          2'b10: begin
            na = (m_dir != 0) ? m_a - 1 : m_a + 1;
            if (na > 15) begin
              na = 14; m_dir = 1; nw = 1;
            end else if (na < 0) begin
              na = 1; m_dir = 0; nw = 1;
            end
          end
          default: ;
        endcase
      end
      m_a = na;
      e.a    = 4'(na);
      e.tick = adv;
      e.wrap = nw[0];
      e.en   = show;
    end
    q_exp.push_back(e);
    @(negedge clk);
    e = q_exp.pop_front();
    chk("a",    32'(a),    32'(e.a));
    chk("tick", 32'(tick), 32'(e.tick));
    chk("wrap", 32'(wrap), 32'(e.wrap));
    chk("en",   32'(en),   32'(e.en));
    if (tick === 1'b1) obs_ticks++;
    if (wrap === 1'b1) obs_wraps++;
  endtask

  initial begin
    int guard;
    reset = 1'b1; run = 1'b0; step = 1'b0; mode = 2'b00; dvsr = '0; show = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;

    // up count, dwell 4
    mode = 2'b00; dvsr = 3; run = 1'b1;
    obs_ticks = 0; obs_wraps = 0;
    repeat (64) cyc();
    chk("up_ticks", 32'(obs_ticks), 32'd16);
    chk("up_wraps", 32'(obs_wraps), 32'd1);
    chk("up_end_a", 32'(a), 32'd0);

    // advance to a=2, then count down every cycle
    guard = 0;
    while (a !== 4'd2 && guard < 20) begin cyc(); guard++; end
    chk("reach_a2", 32'(a), 32'd2);
    mode = 2'b01; dvsr = 0; obs_wraps = 0;
    repeat (4) cyc();
    chk("down_a", 32'(a), 32'd14);
    chk("down_wraps", 32'(obs_wraps), 32'd1);

    // ping-pong from reset
    reset = 1'b1; cyc(); reset = 1'b0;
    mode = 2'b10; dvsr = 0; run = 1'b1; obs_ticks = 0; obs_wraps = 0;
    repeat (31) cyc();
    chk("pp_a", 32'(a), 32'd1);
    chk("pp_ticks", 32'(obs_ticks), 32'd31);
    chk("pp_wraps", 32'(obs_wraps), 32'd2);

    // manual stepping
    reset = 1'b1; run = 1'b0; cyc(); reset = 1'b0;
    mode = 2'b00; obs_ticks = 0;
    step = 1'b1; repeat (5) cyc();
    step = 1'b0; repeat (2) cyc();
    step = 1'b1; cyc();
    step = 1'b0; repeat (2) cyc();
    chk("step_ticks", 32'(obs_ticks), 32'd2);
    chk("step_a", 32'(a), 32'd2);
    run = 1'b1; dvsr = 1000;
    for (int i = 0; i < 6; i++) begin step = ~step; cyc(); end
    step = 1'b0;
    chk("step_run_ticks", 32'(obs_ticks), 32'd2);

    // lowering dvsr below the running count
    reset = 1'b1; cyc(); reset = 1'b0;
    run = 1'b1; dvsr = 100;
    repeat (50) cyc();
    dvsr = 10;
    cyc();
    chk("dv_tick_now", 32'(tick), 32'd1);
    obs_ticks = 0;
    repeat (22) cyc();
    chk("dv_ticks", 32'(obs_ticks), 32'd2);

    // reset mid-run at a=9 with show on
    reset = 1'b1; cyc(); reset = 1'b0;
    show = 1'b1; mode = 2'b00; dvsr = 0; run = 1'b1;
    guard = 0;
    while (a !== 4'd9 && guard < 40) begin cyc(); guard++; end
    chk("reach_a9", 32'(a), 32'd9);
    reset = 1'b1; cyc();
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    reset = 1'b0; dvsr = 2; obs_ticks = 0;
    cyc();
    chk("rel_en", 32'(en), 32'd1);
    cyc(); cyc();
    chk("rel_first_tick", 32'(tick), 32'd1);
    chk("rel_ticks", 32'(obs_ticks), 32'd1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) dvsr = N'($urandom_range(0, 5));
      show = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
